// File: rtl/game_ctrl.sv
// Button conditioning, move-tick divider and IDLE/PLAY/OVER sequencing
// for the game logic block.
module game_ctrl #(
  parameter int MV_DIV    = 416667,
  parameter int DB_CYCLES = 250000,
  parameter int OVER_HOLD = 120
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] btn_raw,
  input  logic       die,
  output logic [2:0] switch_in,
  output logic       current_state,
  output logic       mv,
  output logic       game_over,
  output logic [1:0] state
);

  localparam int DW = $clog2(DB_CYCLES) + 1;
  localparam int MW = $clog2(MV_DIV) + 1;
  localparam int HW = $clog2(OVER_HOLD) + 1;

  localparam logic [DW-1:0] DB_LAST  = DW'(DB_CYCLES - 1);
  localparam logic [MW-1:0] DIV_LAST = MW'(MV_DIV - 1);
  localparam logic [HW-1:0] HOLD_END = HW'(OVER_HOLD);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_OVER = 2'b10
  } state_t;

  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    r_sw;
  logic          r_start_d;
  logic [MW-1:0] r_div;
  logic          r_mv;
  logic [HW-1:0] r_hold;
  state_t        r_state;
  state_t        w_next;
  logic          r_cur;
  logic          r_go;
  logic          w_start_rise;

  // Two-flop synchroniser for the asynchronous buttons
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Per-button debounce: accept a change once it has been stable long enough
  for (genvar g = 0; g < 3; g++) begin : g_db
    logic [DW-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt   <= '0;
        r_sw[g] <= 1'b0;
      end else if (r_sync2[g] == r_sw[g]) begin
        r_cnt <= '0;
      end else if (r_cnt == DB_LAST) begin
        r_cnt   <= '0;
        r_sw[g] <= ~r_sw[g];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Previous debounced start level for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_start_d <= 1'b0;
    else        r_start_d <= r_sw[2];
  end

  assign w_start_rise = r_sw[2] & ~r_start_d;

  // Free-running divider producing the registered move tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
      r_mv  <= 1'b0;
    end else begin
      r_mv  <= (r_div == DIV_LAST);
      r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
    end
  end

  // Move ticks spent in OVER, cleared whenever outside OVER
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_hold <= '0;
    else if (r_state != S_OVER)          r_hold <= '0;
    else if (r_mv && r_hold != HOLD_END) r_hold <= r_hold + 1'b1;
  end

  // Next-state logic; die has priority over start in PLAY
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start_rise) w_next = S_PLAY;
      S_PLAY:  if (die) w_next = S_OVER;
      S_OVER:  if (r_hold == HOLD_END) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register with registered decoded outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cur   <= 1'b0;
      r_go    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cur   <= (w_next == S_PLAY);
      r_go    <= (w_next == S_OVER);
    end
  end

  assign switch_in     = r_sw;
  assign current_state = r_cur;
  assign mv            = r_mv;
  assign game_over     = r_go;
  assign state         = r_state;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed scoreboard bench for game_ctrl with small parameters.
// Observed vector: {switch_in, current_state, mv, game_over, state}.
module tb_game_ctrl;

  logic       clk;
  logic       rst_n;
  logic [2:0] btn_raw;
  logic       die;
  logic [2:0] switch_in;
  logic       current_state;
  logic       mv;
  logic       game_over;
  logic [1:0] state;

  game_ctrl #(
    .MV_DIV(4),
    .DB_CYCLES(3),
    .OVER_HOLD(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .die(die),
    .switch_in(switch_in),
    .current_state(current_state),
    .mv(mv),
    .game_over(game_over),
    .state(state)
  );

  typedef struct {
    int         c;
    logic [7:0] m;
    logic [7:0] v;
    string      n;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   nvec = 0;
  int   nbad = 0;
  int   rel;

  localparam logic [7:0] M_ALL = 8'hFF;
  localparam logic [7:0] M_SW  = 8'hE0;
  localparam logic [7:0] M_MV  = 8'h08;
  localparam logic [7:0] M_FSM = 8'h17;
  localparam logic [7:0] V_IDL = 8'h00;
  localparam logic [7:0] V_PLY = 8'h11;
  localparam logic [7:0] V_OVR = 8'h06;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  wire [7:0] obs = {switch_in, current_state, mv, game_over, state};

  // Monitor: compare every queued expectation due this cycle
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].c < cyc) begin
        nvec++;
        nbad++;
        $display("FAIL %s stale entry cyc=%0d now=%0d", q[i].n, q[i].c, cyc);
        q.delete(i);
      end else if (q[i].c == cyc) begin
        nvec++;
        if ((obs & q[i].m) !== (q[i].v & q[i].m)) begin
          nbad++;
          $display("FAIL %s cyc=%0d got=%b exp=%b mask=%b",
                   q[i].n, cyc, obs & q[i].m, q[i].v & q[i].m, q[i].m);
        end
        q.delete(i);
      end
    end
  end

  task automatic push_exp(input int c, input logic [7:0] m,
                          input logic [7:0] v, input string n);
    exp_t e;
    e.c = c;
    e.m = m;
    e.v = v;
    e.n = n;
    q.push_back(e);
  endtask

  task automatic at(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    btn_raw = 3'b000;
    die     = 1'b0;
    push_exp(2, M_ALL, 8'h00, "reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;

    for (int k = 1; k <= 12; k++)
      push_exp(rel + k, M_MV, (k % 4 == 0) ? 8'h08 : 8'h00, "mv_period");

    at(rel + 13);
    btn_raw[0] = 1'b1;
    for (int k = 1; k <= 8; k++)
      push_exp(rel + 13 + k, M_SW, 8'h00, "glitch_drop");
    at(rel + 15);
    btn_raw[0] = 1'b0;

    at(rel + 23);
    btn_raw[0] = 1'b1;
    push_exp(rel + 27, M_SW, 8'h00, "left_pre");
    push_exp(rel + 28, M_SW, 8'h20, "left_set");
    at(rel + 29);
    btn_raw[0] = 1'b0;
    push_exp(rel + 33, M_SW, 8'h20, "left_hold");
    push_exp(rel + 34, M_SW, 8'h00, "left_clr");

    at(rel + 37);
    btn_raw[2] = 1'b1;
    push_exp(rel + 41, M_SW, 8'h00, "start_pre");
    push_exp(rel + 42, M_SW, 8'h80, "start_set");
    push_exp(rel + 42, M_FSM, V_IDL, "idle_wait");
    push_exp(rel + 43, M_FSM, V_PLY, "to_play");
    at(rel + 45);
    btn_raw[2] = 1'b0;
    push_exp(rel + 46, M_FSM, V_PLY, "play_hold");
    push_exp(rel + 50, M_SW, 8'h00, "start_clr");

    at(rel + 53);
    die = 1'b1;
    push_exp(rel + 53, M_FSM, V_PLY, "pre_die");
    push_exp(rel + 54, M_FSM, V_OVR, "to_over");
    at(rel + 54);
    die = 1'b0;
    push_exp(rel + 61, M_FSM, V_OVR, "over_hold");
    push_exp(rel + 62, M_FSM, V_IDL, "over_idle");

    at(rel + 63);
    btn_raw[2] = 1'b1;
    push_exp(rel + 68, M_FSM, V_IDL, "idle2_wait");
    push_exp(rel + 69, M_FSM, V_PLY, "to_play2");
    at(rel + 67);
    btn_raw[2] = 1'b0;

    at(rel + 73);
    die = 1'b1;
    push_exp(rel + 74, M_FSM, V_OVR, "to_over2");
    at(rel + 74);
    die = 1'b0;
    at(rel + 75);
    btn_raw[2] = 1'b1;
    push_exp(rel + 80, M_SW, 8'h80, "start_in_over");
    push_exp(rel + 81, M_FSM, V_OVR, "over_ign_start");
    push_exp(rel + 82, M_FSM, V_IDL, "over_idle2");
    push_exp(rel + 84, M_FSM, V_IDL, "no_retrigger");
    at(rel + 85);
    btn_raw[2] = 1'b0;

    at(rel + 91);
    btn_raw[2] = 1'b1;
    push_exp(rel + 97, M_FSM, V_PLY, "to_play3");
    at(rel + 95);
    btn_raw[2] = 1'b0;
    at(rel + 101);
    btn_raw[2] = 1'b1;
    at(rel + 106);
    die = 1'b1;
    push_exp(rel + 106, M_FSM, V_PLY, "pre_tie");
    push_exp(rel + 106, M_SW, 8'h80, "tie_start");
    push_exp(rel + 107, M_FSM, V_OVR, "die_wins");
    at(rel + 107);
    die = 1'b0;
    at(rel + 109);
    btn_raw[2] = 1'b0;
    push_exp(rel + 113, M_FSM, V_OVR, "over_hold3");
    push_exp(rel + 114, M_FSM, V_IDL, "over_idle3");

    at(rel + 117);
    btn_raw[2] = 1'b1;
    push_exp(rel + 123, M_FSM, V_PLY, "to_play4");
    push_exp(rel + 127, M_ALL, 8'h91, "play_full");
    push_exp(rel + 128, M_ALL, 8'h00, "async_rst");
    push_exp(rel + 129, M_ALL, 8'h00, "in_rst");
    at(rel + 128);
    #2;
    rst_n   = 1'b0;
    btn_raw = 3'b000;
    #1;
    nvec++;
    if (obs !== 8'h00) begin
      nbad++;
      $display("FAIL async_rst_now got=%b exp=%b", obs, 8'h00);
    end
    at(rel + 130);
    #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++)
      push_exp(rel + 130 + k, M_ALL, 8'h00, "div_restart");
    push_exp(rel + 134, M_ALL, 8'h08, "mv_restart");

    at(rel + 140);
    if (q.size() != 0) begin
      nvec++;
      nbad++;
      $display("FAIL queue_drain left=%0d exp=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
